module_chunked_adder_sequencer: RTL and testbench

- Multi-cycle wide adder built around one module_carry_look_ahead_adder slice.
- Accepts TOTAL-width operands through a valid/ready handshake and feeds the slice one CLA_WIDTH chunk per cycle, LSB chunk first.
- Registers the inter-chunk carry and assembles the full sum, then presents it downstream through a valid/ready handshake.
- Lets the datapath add operands wider than one CLA slice without replicating the slice.

---
 rtl/module_chunked_adder_sequencer.sv | 176 +++++++++++++++++
 tb/tb_module_chunked_adder_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/module_chunked_adder_sequencer.sv
// Multi-cycle wide adder: one CLA slice is reused across NUM_CHUNKS chunks,
// LSB chunk first, with the inter-chunk carry held in a register.

module module_carry_look_ahead_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] grp_g;
  logic [WIDTH-1:0] grp_p;
  logic [WIDTH-1:0] carry_in;

  // Parallel-prefix (Kogge-Stone) carry tree; carry_i is folded into bit 0's
  // generate so grp_g[i] is the carry out of bit i.
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    grp_g    = gen;
    grp_p    = prop;
    grp_g[0] = gen[0] | (prop[0] & carry_i);
    for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
      // Descending order keeps grp_*[i-d] at the previous stage's value.
      for (int unsigned i = WIDTH - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    carry_in    = '0;
    carry_in[0] = carry_i;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry_in[i] = grp_g[i-1];
    end
    sum_o   = prop ^ carry_in;
    carry_o = grp_g[WIDTH-1];
  end

endmodule

module module_chunked_adder_sequencer #(
  parameter int unsigned CLA_WIDTH  = 16,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [CLA_WIDTH*NUM_CHUNKS-1:0]  a_i,
  input  logic [CLA_WIDTH*NUM_CHUNKS-1:0]  b_i,
  input  logic                             carry_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [CLA_WIDTH*NUM_CHUNKS-1:0]  sum_o,
  output logic                             carry_o,
  output logic                             busy_o
);

  localparam int unsigned TOTAL = CLA_WIDTH * NUM_CHUNKS;
  localparam int unsigned CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [TOTAL-1:0]   a_q, a_d;
  logic [TOTAL-1:0]   b_q, b_d;
  logic [TOTAL-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [CLA_WIDTH-1:0] a_chunk;
  logic [CLA_WIDTH-1:0] b_chunk;
  logic [CLA_WIDTH-1:0] slice_sum;
  logic                 slice_carry;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_chunk = a_q[i*CLA_WIDTH +: CLA_WIDTH];
        b_chunk = b_q[i*CLA_WIDTH +: CLA_WIDTH];
      end
    end
  end

  module_carry_look_ahead_adder #(
    .WIDTH (CLA_WIDTH)
  ) u_cla (
    .a_i     (a_chunk),
    .b_i     (b_chunk),
    .carry_i (carry_q),
    .sum_o   (slice_sum),
    .carry_o (slice_carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = carry_i;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[i*CLA_WIDTH +: CLA_WIDTH] = slice_sum;
          end
        end
        carry_d = slice_carry;
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q == ADD);
  assign sum_o   = sum_q;
  assign carry_o = cout_q;

endmodule

// File: tb/tb_module_chunked_adder_sequencer.sv
// Directed and random checks of the chunked adder sequencer against a
// queue of expected {carry, sum} values computed at 65 bits.

module tb_module_chunked_adder_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned TW = CW * NC;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [TW-1:0] a_i;
  logic [TW-1:0] b_i;
  logic          carry_i;
  logic          valid_o;
  logic          ready_i;
  logic [TW-1:0] sum_o;
  logic          carry_o;
  logic          busy_o;

  logic [TW:0]   exp_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   n_res = 0;

  module_chunked_adder_sequencer #(
    .CLA_WIDTH  (CW),
    .NUM_CHUNKS (NC)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [TW:0] obs, input logic [TW:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic drive_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c);
    a_i     = a;
    b_i     = b;
    carry_i = c;
    valid_i = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + (TW+1)'(c));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with operand inputs scrambled so later changes would corrupt a bad design.
  task automatic wait_accept();
    int unsigned t = 0;
    while (!ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      timeout_fail("accept_timeout");
      valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i     = {$urandom, $urandom};
    b_i     = {$urandom, $urandom};
    carry_i = 1'($urandom_range(0, 1));
  endtask

  task automatic receive(input bit rand_ready);
    for (int unsigned t = 0; t < 200; t++) begin
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_o && ready_i) begin
        n_res++;
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_result");
        end else begin
          chk("result", {carry_o, sum_o}, exp_q.pop_front());
        end
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        return;
      end
      @(negedge clk_i);
    end
    ready_i = 1'b0;
    timeout_fail("result_timeout");
  endtask

  initial begin
    int unsigned base;
    int unsigned t;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    carry_i = 1'b0;

    #13;
    chk("rst_ready", (TW+1)'(ready_o), (TW+1)'(1));
    chk("rst_valid", (TW+1)'(valid_o), '0);
    chk("rst_busy", (TW+1)'(busy_o), '0);
    chk("rst_result", {carry_o, sum_o}, '0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Basic add with latency / busy window
    drive_op(64'h1, 64'h2, 1'b0);
    wait_accept();
    for (int i = 0; i < 4; i++) begin
      chk("basic_busy", (TW+1)'(busy_o), (TW+1)'(1));
      chk("basic_valid_early", (TW+1)'(valid_o), '0);
      @(negedge clk_i);
    end
    chk("basic_valid_latency", (TW+1)'(valid_o), (TW+1)'(1));
    chk("basic_busy_done", (TW+1)'(busy_o), '0);
    receive(1'b0);
    chk("basic_sum", {carry_o, sum_o}, {1'b0, 64'h3});

    // Full ripple
    drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_accept();
    receive(1'b0);
    chk("ripple_sum", {carry_o, sum_o}, {1'b1, 64'h0});

    // Chunk-boundary carry
    drive_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_accept();
    receive(1'b0);
    chk("boundary_sum", {carry_o, sum_o}, {1'b0, 64'h0000_0000_0001_0000});

    // Backpressure with new operands pending
    drive_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_accept();
    t = 0;
    while (!valid_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (!valid_o) timeout_fail("bp_valid_timeout");
    drive_op(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", (TW+1)'(valid_o), (TW+1)'(1));
      chk("bp_ready_low", (TW+1)'(ready_o), '0);
      chk("bp_result_hold", {carry_o, sum_o}, exp_q[0]);
      @(negedge clk_i);
    end
    receive(1'b0);
    wait_accept();
    receive(1'b0);
    chk("bp_second_sum", {carry_o, sum_o}, {1'b1, 64'h0000_0000_0000_0002});

    // Reset during the second ADD cycle
    drive_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1);
    wait_accept();
    @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midrst_valid", (TW+1)'(valid_o), '0);
    chk("midrst_busy", (TW+1)'(busy_o), '0);
    chk("midrst_ready", (TW+1)'(ready_o), (TW+1)'(1));
    chk("midrst_result", {carry_o, sum_o}, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("midrst_no_pulse", (TW+1)'({valid_o, busy_o}), '0);
    end
    drive_op(64'h1234, 64'h4321, 1'b0);
    wait_accept();
    receive(1'b0);
    chk("post_reset_sum", {carry_o, sum_o}, {1'b0, 64'h5555});

    // Random back-to-back operations with random downstream readiness
    base = n_res;
    for (int i = 0; i < 200; i++) begin
      drive_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_accept();
      receive(1'b1);
    end
    chk("rand_count", (TW+1)'(n_res - base), (TW+1)'(200));
    chk("queue_empty", (TW+1)'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
